// File: rtl/alu_multiword_seq.sv
// -----------------------------------------------------------------------------
// alu_multiword_seq
//
// Purpose:
//   Sequences a multi-word (NWORDS x WIDTH bit) AND/OR/ADD/SUB through an
//   external single-word ALU. One word is processed per clock, least
//   significant word first. Carry (ADD) or borrow (SUB) is chained from the
//   ALU flag output back into the ALU flag input of the next word.
//   A start/busy/done handshake frames each operation.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   start             operation request, only sampled while idle
//   op                00 AND, 01 OR, 10 ADD, 11 SUB
//   opa, opb          full-width operands, captured when start is accepted
//   busy              high while words are being processed
//   done              one-cycle pulse when result/flags are valid
//   result            full-width result, held until the next accepted start
//   carry_out         final carry (ADD) / borrow (SUB), 0 for AND/OR
//   zero              result == 0
//   alu_a, alu_b      operand words to the ALU (0 when not running)
//   alu_ctrl          ALU operation select (0 when not running)
//   alu_flag_in       chained carry/borrow into the ALU (0 when not running)
//   alu_result        ALU result word (combinational from the ALU)
//   alu_flag_out      ALU carry/borrow out (combinational from the ALU)
//
// Optional feature (macro ALU_SEQ_OVF_EN):
//   When defined, adds output ovf: signed overflow of the full-width ADD/SUB,
//   0 for AND/OR, updated together with carry_out/zero.
// -----------------------------------------------------------------------------
module alu_multiword_seq #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [WIDTH*NWORDS-1:0]   opa,
    input  logic [WIDTH*NWORDS-1:0]   opb,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*NWORDS-1:0]   result,
    output logic                      carry_out,
    output logic                      zero,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [1:0]                alu_ctrl,
    output logic                      alu_flag_in,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic                      alu_flag_out
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int TOTAL = WIDTH * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TOTAL-1:0]    opa_q, opa_d;
    logic [TOTAL-1:0]    opb_q, opb_d;
    logic [1:0]          op_q, op_d;
    logic                c_q, c_d;
    logic [TOTAL-1:0]    result_q, result_d;
    logic                carry_out_q, carry_out_d;
    logic                zero_q, zero_d;

    // Operand words as arrays so the active word is a simple index.
    logic [WIDTH-1:0]    opa_words [NWORDS];
    logic [WIDTH-1:0]    opb_words [NWORDS];

    // Result with the word currently coming back from the ALU merged in.
    // Used both as the next result register value and for the zero flag,
    // so zero already sees the final word on the edge into DONE.
    logic [TOTAL-1:0]    result_merged;

    logic                is_arith;
    logic                run_word;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign run_word = (state_q == S_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign opa_words[gi] = opa_q[gi*WIDTH +: WIDTH];
            assign opb_words[gi] = opb_q[gi*WIDTH +: WIDTH];
            assign result_merged[gi*WIDTH +: WIDTH] =
                (run_word && (idx_q == IDX_W'(gi))) ? alu_result
                                                    : result_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic a_msb, b_msb, r_msb;

    // Sign bits of the most significant word; only meaningful on the last
    // RUN cycle, which is the only time ovf_d is taken.
    assign a_msb = opa_words[LAST_IDX][WIDTH-1];
    assign b_msb = opb_words[LAST_IDX][WIDTH-1];
    assign r_msb = alu_result[WIDTH-1];
`endif

    // Next-state and ALU drive
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        c_d         = c_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
`ifdef ALU_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = 2'b00;
        alu_flag_in = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    opa_d   = opa;
                    opb_d   = opb;
                    op_d    = op;
                    c_d     = 1'b0;
                end
            end

            S_RUN: begin
                alu_a       = opa_words[idx_q];
                alu_b       = opb_words[idx_q];
                alu_ctrl    = op_q;
                alu_flag_in = is_arith ? c_q : 1'b0;
                result_d    = result_merged;
                c_d         = alu_flag_out;
                if (idx_q == LAST_IDX) begin
                    // idx holds at the last word; only a new start rewinds it.
                    state_d     = S_DONE;
                    carry_out_d = is_arith ? alu_flag_out : 1'b0;
                    zero_d      = (result_merged == '0);
`ifdef ALU_SEQ_OVF_EN
                    case (op_q)
                        OP_ADD:  ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
                        OP_SUB:  ovf_d = (a_msb != b_msb) && (r_msb != a_msb);
                        default: ovf_d = 1'b0;
                    endcase
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_q        <= 2'b00;
            c_q         <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            c_q         <= c_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;
`ifdef ALU_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
